// File: rtl/pipeline_pkg.sv
// Shared types and constants for the pipeline stream endpoints.
package pipeline_pkg;
  localparam int VALUE_W = 8;
  typedef logic [VALUE_W-1:0] value_t;

  // Fibonacci taps 8,6,5,4 expressed as a mask over lfsr[7:0].
  localparam logic [7:0] LFSR_TAPS      = 8'hB8;
  localparam value_t     FIRST_EXPECTED = 8'd1;

  function automatic logic [7:0] lfsr_step(input logic [7:0] s);
    return {s[6:0], ^(s & LFSR_TAPS)};
  endfunction
endpackage

// File: rtl/pipeline_if.sv
// Valid/ready stream. A beat transfers on a rising edge where valid & ready.
// The master holds value stable while valid & ~ready; ready never depends on valid.
interface pipeline_if #(parameter int WIDTH = 8);
  logic [WIDTH-1:0] value;
  logic             valid;
  logic             ready;

  modport master (output value, output valid, input ready);
  modport slave  (input value, input valid, output ready);
endinterface

// File: rtl/pipeline_skid_buffer.sv
// Two-entry (main + skid) buffer whose ready output is a register, so upstream
// ready has no combinational path from downstream pop.
module pipeline_skid_buffer #(
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_value,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] main_value,
  output logic             main_valid,
  input  logic             pop
);
  logic [WIDTH-1:0] main_q, main_d, skid_q, skid_d;
  logic             main_valid_q, main_valid_d, skid_valid_q, skid_valid_d;
  logic             accept;

  assign accept     = in_valid & in_ready;
  assign main_value = main_q;
  assign main_valid = main_valid_q;

  // in_ready is low whenever skid is full, so pop with a full skid never sees an accept.
  always_comb begin
    main_d       = main_q;
    main_valid_d = main_valid_q;
    skid_d       = skid_q;
    skid_valid_d = skid_valid_q;
    if (pop && main_valid_q) begin
      if (skid_valid_q) begin
        main_d       = skid_q;
        skid_valid_d = 1'b0;
      end else begin
        main_d       = in_value;
        main_valid_d = accept;
      end
    end else if (accept) begin
      if (main_valid_q) begin
        skid_d       = in_value;
        skid_valid_d = 1'b1;
      end else begin
        main_d       = in_value;
        main_valid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      main_q       <= '0;
      main_valid_q <= 1'b0;
      skid_q       <= '0;
      skid_valid_q <= 1'b0;
      in_ready     <= 1'b0;
    end else begin
      main_q       <= main_d;
      main_valid_q <= main_valid_d;
      skid_q       <= skid_d;
      skid_valid_q <= skid_valid_d;
      in_ready     <= ~skid_valid_d;
    end
  end
endmodule

// File: rtl/pipeline_input.sv
// Stream sink: skid-buffered accept, LFSR-throttled consume, and an
// incrementing-sequence checker reporting count, errors and last value.
module pipeline_input
  import pipeline_pkg::*;
#(
  parameter int         WIDTH    = 8,
  parameter int         CNT_W    = 16,
  parameter int         ERR_W    = 8,
  parameter bit         STALL_EN = 1'b1,
  parameter logic [7:0] SEED     = 8'hA5
) (
  input  logic             clock,
  input  logic             reset,
  pipeline_if.slave        stream,
  output logic [CNT_W-1:0] o_count,
  output logic [ERR_W-1:0] o_errors,
  output logic             o_mismatch,
  output logic [WIDTH-1:0] o_last
);
  if (SEED == 8'h00) begin : g_seed_check
    $error("pipeline_input: SEED must be nonzero");
  end

  logic [7:0]       lfsr;
  logic             en;
  logic             consume;
  logic [WIDTH-1:0] main_value;
  logic             main_valid;
  logic [WIDTH-1:0] expected;

  pipeline_skid_buffer #(.WIDTH(WIDTH)) u_skid (
    .clock      (clock),
    .reset      (reset),
    .in_value   (stream.value),
    .in_valid   (stream.valid),
    .in_ready   (stream.ready),
    .main_value (main_value),
    .main_valid (main_valid),
    .pop        (consume)
  );

  // Stall when the low three LFSR bits are all zero: roughly one cycle in eight.
  assign en      = STALL_EN ? (lfsr[2:0] != 3'b000) : 1'b1;
  assign consume = main_valid & en;

  always_ff @(posedge clock) begin
    if (reset) lfsr <= SEED;
    else       lfsr <= lfsr_step(lfsr);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      expected   <= WIDTH'(FIRST_EXPECTED);
      o_count    <= '0;
      o_errors   <= '0;
      o_mismatch <= 1'b0;
      o_last     <= '0;
    end else begin
      o_mismatch <= 1'b0;
      if (consume) begin
        o_last   <= main_value;
        o_count  <= o_count + CNT_W'(1);
        // Resynchronise on the received value so one bad beat costs one error.
        expected <= main_value + WIDTH'(1);
        if (main_value != expected) begin
          o_mismatch <= 1'b1;
          if (o_errors != '1) o_errors <= o_errors + ERR_W'(1);
        end
      end
    end
  end
endmodule

// File: tb/tb_pipeline_input.sv
// Directed bench: one non-stalling and one stalling sink on a shared clock/reset.
module tb_pipeline_input;
  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  pipeline_if #(.WIDTH(8)) s0 ();
  pipeline_if #(.WIDTH(8)) s1 ();

  logic [15:0] count0, count1;
  logic [7:0]  errors0, errors1, last0, last1;
  logic        mm0, mm1;

  pipeline_input #(.STALL_EN(1'b0)) dut0 (
    .clock(clock), .reset(reset), .stream(s0.slave),
    .o_count(count0), .o_errors(errors0), .o_mismatch(mm0), .o_last(last0)
  );
  pipeline_input #(.STALL_EN(1'b1)) dut1 (
    .clock(clock), .reset(reset), .stream(s1.slave),
    .o_count(count1), .o_errors(errors1), .o_mismatch(mm1), .o_last(last1)
  );

  int tests = 0;
  int fails = 0;
  int mm0_pulses = 0;
  int mm1_pulses = 0;
  int s0_low_cycles = 0;
  logic s1_saw_low = 1'b0;
  logic [7:0] last_at_mm0 = 8'h00;

  // Mismatch pulses last exactly one cycle, so negedge sampling sees each once.
  always @(negedge clock) begin
    if (!reset) begin
      if (mm0) begin mm0_pulses++; last_at_mm0 = last0; end
      if (mm1) mm1_pulses++;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the beat transferred.
  task automatic send(input int sel, input logic [7:0] v);
    int waits;
    waits = 0;
    if (sel == 0) begin s0.value = v; s0.valid = 1'b1; end
    else          begin s1.value = v; s1.valid = 1'b1; end
    while (!((sel == 0) ? s0.ready : s1.ready) && waits < 100) begin
      if (sel == 0) s0_low_cycles++;
      else          s1_saw_low = 1'b1;
      @(negedge clock);
      waits++;
    end
    if (waits >= 100) check("send_timeout", waits, 0);
    @(posedge clock);
    @(negedge clock);
    if (sel == 0) s0.valid = 1'b0;
    else          s1.valid = 1'b0;
  endtask

  task automatic reset_duts();
    reset = 1'b1;
    s0.valid = 1'b0;
    s1.valid = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    mm0_pulses = 0;
    mm1_pulses = 0;
    s0_low_cycles = 0;
    s1_saw_low = 1'b0;
  endtask

  initial begin
    int n;
    s0.value = 8'h00; s0.valid = 1'b0;
    s1.value = 8'h00; s1.valid = 1'b0;

    // Reset held for three cycles.
    repeat (3) @(negedge clock);
    check("rst_ready", s0.ready, 0);
    check("rst_count", count0, 0);
    check("rst_errors", errors0, 0);
    check("rst_last", last0, 0);
    check("rst_mismatch", mm0, 0);
    reset = 1'b0;
    check("rst_ready_before_edge", s0.ready, 0);
    @(negedge clock);
    check("ready_after_release", s0.ready, 1);
    check("ready_after_release_stall", s1.ready, 1);
    check("no_pulse_after_release", mm0 | mm1, 0);

    // 300 back-to-back beats, 1..300 modulo 256.
    for (int i = 1; i <= 300; i++) send(0, 8'(i));
    repeat (3) @(negedge clock);
    check("b2b_count", count0, 300);
    check("b2b_errors", errors0, 0);
    check("b2b_last", last0, 8'h2C);
    check("b2b_ready_low_cycles", s0_low_cycles, 0);
    check("b2b_pulses", mm0_pulses, 0);

    // Continue through ...FE, FF, 00, 01.
    for (int v = 45; v <= 255; v++) send(0, 8'(v));
    send(0, 8'h00);
    send(0, 8'h01);
    repeat (3) @(negedge clock);
    check("wrap_count", count0, 513);
    check("wrap_errors", errors0, 0);
    check("wrap_pulses", mm0_pulses, 0);
    check("wrap_last", last0, 8'h01);

    // 1,2,7,8: one error, on the 7.
    reset_duts();
    send(0, 8'd1);
    send(0, 8'd2);
    send(0, 8'd7);
    send(0, 8'd8);
    repeat (3) @(negedge clock);
    check("gap_pulses", mm0_pulses, 1);
    check("gap_pulse_value", last_at_mm0, 8'd7);
    check("gap_errors", errors0, 1);
    check("gap_count", count0, 4);
    check("gap_last", last0, 8'd8);

    // Stalling sink, 1000 continuous beats.
    reset_duts();
    for (int i = 1; i <= 1000; i++) send(1, 8'(i));
    n = 0;
    while (count1 != 16'd1000 && n < 100) begin @(negedge clock); n++; end
    check("stall_count", count1, 1000);
    check("stall_errors", errors1, 0);
    check("stall_pulses", mm1_pulses, 0);
    check("stall_last", last1, 8'hE8);
    check("stall_ready_dropped", s1_saw_low, 1);

    // Error counter saturation.
    reset_duts();
    for (int i = 0; i < 300; i++) send(0, 8'h00);
    repeat (3) @(negedge clock);
    check("sat_errors", errors0, 8'hFF);
    check("sat_count", count0, 300);
    check("sat_pulses", mm0_pulses, 300);

    // Fill the stalling sink's skid entry, then reset on top of it.
    reset_duts();
    s1.value = 8'd1;
    s1.valid = 1'b1;
    n = 0;
    while (s1.ready && n < 200) begin
      @(posedge clock);
      @(negedge clock);
      s1.value = s1.value + 8'd1;
      n++;
    end
    check("skid_filled", s1.ready, 0);
    reset = 1'b1;
    s1.valid = 1'b0;
    @(negedge clock);
    check("midrst_count", count1, 0);
    check("midrst_errors", errors1, 0);
    check("midrst_last", last1, 0);
    check("midrst_ready", s1.ready, 0);
    reset = 1'b0;
    @(negedge clock);
    check("midrst_ready_after", s1.ready, 1);
    mm1_pulses = 0;
    send(1, 8'd1);
    n = 0;
    while (count1 != 16'd1 && n < 50) begin @(negedge clock); n++; end
    repeat (3) @(negedge clock);
    check("midrst_post_count", count1, 1);
    check("midrst_post_errors", errors1, 0);
    check("midrst_post_last", last1, 8'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
